jk_counter_sequencer: RTL
=========================

// Module: jk_counter_sequencer
// PURPOSE
//  Run controller for the 4-bit JK up-counter: starts it from zero, gates its count_enable,
//  detects the programmed terminal count, then clears it. One-shot or periodic (auto-reload).
//  Sits between the control logic and the counter. Drives its count_enable and clear pins,
//  and watches its q outputs.
// PARAMETERS
//  WIDTH   4  width of the sequenced counter and of term/cnt_q
//  PCNT_W  8  width of the completed-period counter
// PORTS
//  clock        in   1        single system clock, rising edge
//  clear        in   1        reset, asynchronous, active-low
//  start        in   1        begin a run (sampled in IDLE only)
//  stop         in   1        abort run, return to IDLE (highest priority)
//  hold         in   1        pause counting while 1 (RUN only)
//  periodic     in   1        1 = auto-restart after terminal count, 0 = one-shot
//  term         in   WIDTH    terminal count T
//  cnt_q        in   WIDTH    counter q outputs
//  cnt_en       out  1        to counter count_enable (combinational)
//  cnt_clear    out  1        to counter clear, active-low, registered (glitch-free)
//  busy         out  1        1 in RUN and DONE
//  done         out  1        one-cycle pulse per completed period, registered
//  periods      out  PCNT_W   completed periods since last start
// BEHAVIOUR
//  Reset (clear=0):
//    state=IDLE, cnt_clear=0, done=0, periods=0, term_q=0.
//    Outputs derived from state give busy=0 and cnt_en=0.
//  States: IDLE, RUN, DONE. cnt_clear is registered as next_state==RUN.
//    Counter is held at 0 in IDLE and DONE.
//  IDLE:
//    start=1 & stop=0 -> RUN. Latch term_q<=term, periods<=0.
//    start and stop together -> stay IDLE.
//  RUN:
//    cnt_en = ~hold & (cnt_q != term_q).
//    stop=1 -> IDLE (counter cleared next cycle).
//    Else if cnt_q==term_q (hold ignored) -> DONE; done<=1; periods<=periods+1, wrapping 2^PCNT_W-1 -> 0.
//  DONE (exactly one cycle, cnt_en=0, done=1):
//    stop=1 -> IDLE.
//    periodic=1 -> RUN, re-latch term_q<=term.
//    Else -> IDLE.
//  Timing, start captured at edge E0:
//    counter increments at E1..ET and shows T after ET; cnt_en drops in that cycle.
//    DONE is entered at E(T+1): done=1 and counter cleared.
//    Period is T+2 cycles when hold=0.
//  T=0: RUN->DONE on the first RUN cycle, no increments; periodic period = 2 cycles.
//  cnt_q > term_q (e.g. term lowered mid-run is impossible since term_q is latched,
//    but counter corruption can cause it): keep counting.
//    Counter wraps 15->0 and continues to T. Equality compare only, no ordering compare.
//  start while busy: ignored. term changes mid-run: no effect until the next latch.
//  Reset mid-run: immediate IDLE, cnt_clear=0 asynchronously, counter cleared.
// TESTING
//  1. Reset, then term=5, periodic=0, start pulse
//     -> cnt_q 0..5; done high exactly 1 cycle at E6; busy falls after E7; periods=1; cnt_q=0.
//  2. term=3, periodic=1, run 4 periods
//     -> done every 5 cycles; periods 1,2,3,4; cnt_q pattern 0,1,2,3,0 repeating.
//  3. term=9, hold=1 for 3 cycles after cnt_q=4
//     -> cnt_q stays 4 for 3 cycles; done delayed by exactly 3 cycles (at E13).
//  4. term=15, then term=0 in periodic mode
//     -> full count to 15 with no wrap, then done; T=0 gives done every 2 cycles and cnt_en never 1.
//  5. stop at cnt_q=6 (term=10); separately, start+stop in the same IDLE cycle
//     -> IDLE next cycle, cnt_clear=0, no done; the start+stop case stays IDLE.
//  6. Assert clear mid-run at cnt_q=7; also run periodic past 256 periods (PCNT_W=8)
//     -> all outputs at reset values immediately; periods wraps 255->0.

Source files
------------

// File: rtl/jk_counter_sequencer.sv
// jk_counter_sequencer: run controller that starts, gates, terminates and clears a JK up-counter
module jk_counter_sequencer #(
  parameter int WIDTH  = 4,
  parameter int PCNT_W = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  input  logic              periodic,
  input  logic [WIDTH-1:0]  term,
  input  logic [WIDTH-1:0]  cnt_q,
  output logic              cnt_en,
  output logic              cnt_clear,
  output logic              busy,
  output logic              done,
  output logic [PCNT_W-1:0] periods
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, next_state;
  logic [WIDTH-1:0] term_q;
  logic             at_term, launch, reload, finish;
  // next-state and combinational outputs; equality-only terminal compare so a corrupted count wraps back to term
  always_comb begin
    at_term    = cnt_q == term_q;
    launch     = state == IDLE && start && !stop;
    reload     = state == DONE && !stop && periodic;
    finish     = state == RUN && !stop && at_term;
    cnt_en     = state == RUN && !hold && !at_term;
    busy       = state != IDLE;
    next_state = state;
    case (state)
      IDLE:    next_state = launch ? RUN : IDLE;
      RUN:     next_state = stop ? IDLE : at_term ? DONE : RUN;
      DONE:    next_state = reload ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end
  // state register plus registered counter clear, done pulse, period count and latched terminal
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= IDLE;
      cnt_clear <= 1'b0;
      done      <= 1'b0;
      periods   <= '0;
      term_q    <= '0;
    end else begin
      state     <= next_state;
      cnt_clear <= next_state == RUN;
      done      <= finish;
      periods   <= launch ? '0 : finish ? periods + 1'b1 : periods;
      term_q    <= (launch || reload) ? term : term_q;
    end
  end
endmodule
